// File: rtl/echo_seq_pkg.sv
// rtl/echo_seq_pkg.sv - state encoding, stage codes and timing defaults for the echo stage sequencer
package echo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV_EN   = 3'd1,
    CONV_WAIT = 3'd2,
    LAG_EN    = 3'd3,
    LAG_WAIT  = 3'd4,
    PROC_EN   = 3'd5,
    PROC_WAIT = 3'd6,
    OUT       = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    STAGE_CONV = 2'd0,
    STAGE_LAG  = 2'd1,
    STAGE_PROC = 2'd2
  } stage_e;

  localparam int CNT_W_DEF          = 13;
  localparam int PULSE_CYCLES_DEF   = 2;
  localparam int ARM_CYCLES_DEF     = 2;
  localparam int TIMEOUT_CYCLES_DEF = 2048;

  function automatic stage_e stage_of(input seq_state_e s);
    case (s)
      CONV_EN, CONV_WAIT: stage_of = STAGE_CONV;
      LAG_EN, LAG_WAIT:   stage_of = STAGE_LAG;
      default:            stage_of = STAGE_PROC;
    endcase
  endfunction

endpackage

// File: rtl/seq_stage_timer.sv
// rtl/seq_stage_timer.sv - loadable up-counter timing enable pulses, ready arming and wait timeouts
module seq_stage_timer
  import echo_seq_pkg::*;
#(
  parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int ARM_CYCLES     = ARM_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_operation,
  input  logic rst,
  input  logic load,
  output logic pulse_done,
  output logic arm_done,
  output logic timeout_hit
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // Count is 0 in the first cycle of a state; saturates so IDLE can never wrap it.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (cnt != {W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pulse_done  = (cnt == W'(PULSE_CYCLES - 1));
  assign arm_done    = (cnt >= W'(ARM_CYCLES));
  assign timeout_hit = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/echo_stage_sequencer.sv
// rtl/echo_stage_sequencer.sv - per-sample stage enable sequencer; ECHO_SEQ_PROFILE_EN adds latency profiling
module echo_stage_sequencer
  import echo_seq_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int ARM_CYCLES     = ARM_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk_operation,
  input  logic             rst,
  input  logic [CNT_W-1:0] sampling_cycle_counter,
  input  logic             mode_adapt,
  input  logic             ready_conv,
  input  logic             ready_lag,
  input  logic             ready_adapt,
  input  logic             ready_cancel,
  output logic             enable_conv,
  output logic             enable_lag,
  output logic             enable_adapt,
  output logic             enable_cancel,
  output logic             out_valid,
  output logic             out_sel,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err,
  output logic [15:0]      frame_count,
  output logic [15:0]      last_latency
);

  seq_state_e state, state_nxt;
  logic       mode_q;
  logic       tick, accept, ready_sel, timeout_evt;
  logic       pulse_done, arm_done, timeout_hit;

  assign tick   = (sampling_cycle_counter == '0);
  assign accept = tick && (state == IDLE);
  assign busy   = (state != IDLE);

  seq_stage_timer #(
    .PULSE_CYCLES   (PULSE_CYCLES),
    .ARM_CYCLES     (ARM_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_operation (clk_operation),
    .rst           (rst),
    .load          (state_nxt != state),
    .pulse_done    (pulse_done),
    .arm_done      (arm_done),
    .timeout_hit   (timeout_hit)
  );

  always_comb begin
    case (stage_of(state))
      STAGE_CONV: ready_sel = ready_conv;
      STAGE_LAG:  ready_sel = ready_lag;
      default:    ready_sel = mode_q ? ready_adapt : ready_cancel;
    endcase
  end

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    case (state)
      IDLE:    if (tick) state_nxt = CONV_EN;
      CONV_EN: if (pulse_done) state_nxt = CONV_WAIT;
      LAG_EN:  if (pulse_done) state_nxt = LAG_WAIT;
      PROC_EN: if (pulse_done) state_nxt = PROC_WAIT;
      CONV_WAIT, LAG_WAIT, PROC_WAIT: begin
        // A ready arriving on the timeout cycle still wins.
        if (arm_done && ready_sel) begin
          state_nxt = (state == CONV_WAIT) ? LAG_EN :
                      (state == LAG_WAIT)  ? PROC_EN : OUT;
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          timeout_evt = 1'b1;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      mode_q        <= 1'b0;
      enable_conv   <= 1'b0;
      enable_lag    <= 1'b0;
      enable_adapt  <= 1'b0;
      enable_cancel <= 1'b0;
      out_valid     <= 1'b0;
      out_sel       <= 1'b0;
      timeout_err   <= 1'b0;
      overrun_err   <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      if (accept) mode_q <= mode_adapt;
      enable_conv   <= (state_nxt == CONV_EN);
      enable_lag    <= (state_nxt == LAG_EN);
      enable_adapt  <= (state_nxt == PROC_EN) && mode_q;
      enable_cancel <= (state_nxt == PROC_EN) && !mode_q;
      out_valid     <= (state_nxt == OUT);
      out_sel       <= (state_nxt == OUT) && !mode_q;
      if (timeout_evt)    timeout_err <= 1'b1;
      if (tick && busy)   overrun_err <= 1'b1;
      if (state_nxt == OUT) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef ECHO_SEQ_PROFILE_EN
  logic [15:0] lat_cnt, lat_inc;

  assign lat_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

  // lat_cnt holds cycles elapsed since the tick cycle, so OUT entry captures tick-to-out_valid.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      lat_cnt      <= 16'd0;
      last_latency <= 16'd0;
    end else begin
      if (accept)    lat_cnt <= 16'd1;
      else if (busy) lat_cnt <= lat_inc;
      if (state_nxt == OUT) last_latency <= lat_inc;
    end
  end
`else
  assign last_latency = 16'd0;
`endif

endmodule

// File: tb/tb_echo_stage_sequencer.sv
// tb/tb_echo_stage_sequencer.sv - scoreboard bench for echo_stage_sequencer
module tb_echo_stage_sequencer;

  localparam int PULSE   = 2;
  localparam int ARM     = 2;
  localparam int TIMEOUT = 2048;
  localparam int D       = 10;
`ifdef ECHO_SEQ_PROFILE_EN
  localparam bit PROF = 1'b1;
`else
  localparam bit PROF = 1'b0;
`endif

  typedef struct {
    logic sel;
    int   fc;
    int   n_adapt;
    int   n_cancel;
    int   lat;
    int   tick_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] scc;
  logic        mode;
  logic        enable_conv, enable_lag, enable_adapt, enable_cancel;
  logic        out_valid, out_sel, busy, timeout_err, overrun_err;
  logic [15:0] frame_count, last_latency;
  logic        ready_conv, ready_lag, ready_adapt, ready_cancel;

  logic [3:0] rdy = 4'b0;
  logic [3:0] sm_prev = 4'b0;
  logic [3:0] mon_prev = 4'b0;
  int         dcnt[4] = '{0, 0, 0, 0};
  int         pw[4] = '{0, 0, 0, 0};
  bit         conv_stuck = 1'b0;
  bit         lag_stuck = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tick_cyc = 0;
  int   lag_rise_cyc = 0;
  int   n_adapt = 0;
  int   n_cancel = 0;
  int   fc_model = 0;
  exp_t sb[$];

  wire [3:0] en_v = {enable_cancel, enable_adapt, enable_lag, enable_conv};

  assign ready_conv   = conv_stuck | rdy[0];
  assign ready_lag    = !lag_stuck & rdy[1];
  assign ready_adapt  = rdy[2];
  assign ready_cancel = rdy[3];

  echo_stage_sequencer dut (
    .clk_operation          (clk),
    .rst                    (rst),
    .sampling_cycle_counter (scc),
    .mode_adapt             (mode),
    .ready_conv             (ready_conv),
    .ready_lag              (ready_lag),
    .ready_adapt            (ready_adapt),
    .ready_cancel           (ready_cancel),
    .enable_conv            (enable_conv),
    .enable_lag             (enable_lag),
    .enable_adapt           (enable_adapt),
    .enable_cancel          (enable_cancel),
    .out_valid              (out_valid),
    .out_sel                (out_sel),
    .busy                   (busy),
    .timeout_err            (timeout_err),
    .overrun_err            (overrun_err),
    .frame_count            (frame_count),
    .last_latency           (last_latency)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_lat(input bit stuck);
    return 1 + (stuck ? (PULSE + ARM + 1) : (D + 1)) + 2 * (D + 1);
  endfunction

  // Stage models: ready drops on enable rise and returns D cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en_v[i] && !sm_prev[i]) begin
        dcnt[i] = D;
        rdy[i]  = 1'b0;
      end else if (dcnt[i] > 0) begin
        dcnt[i]--;
        if (dcnt[i] == 0) rdy[i] = 1'b1;
      end
    end
    sm_prev = en_v;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) pw[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (en_v[i]) pw[i]++;
        else if (pw[i] != 0) begin
          check($sformatf("pulse_width_%0d", i), pw[i], PULSE);
          pw[i] = 0;
        end
      end
      if (en_v[1] && !mon_prev[1]) lag_rise_cyc = cyc;
      if (en_v[2] && !mon_prev[2]) n_adapt++;
      if (en_v[3] && !mon_prev[3]) n_cancel++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_sel", out_sel, e.sel);
          check("frame_count", frame_count, e.fc);
          check("adapt_pulses", n_adapt, e.n_adapt);
          check("cancel_pulses", n_cancel, e.n_cancel);
          check("latency", cyc - e.tick_cyc, e.lat);
          check("last_latency", last_latency, PROF ? e.lat : 0);
        end
      end
    end
    mon_prev = en_v;
  end

  task automatic tick(input bit push_exp, input bit stuck);
    exp_t e;
    @(negedge clk);
    scc      = 13'd0;
    tick_cyc = cyc;
    n_adapt  = 0;
    n_cancel = 0;
    if (push_exp) begin
      fc_model++;
      e.sel      = !mode;
      e.fc       = fc_model;
      e.n_adapt  = mode ? 1 : 0;
      e.n_cancel = mode ? 0 : 1;
      e.lat      = exp_lat(stuck);
      e.tick_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    scc = 13'd1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_wait_expired", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst  = 1'b1;
    scc  = 13'd1;
    mode = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enables", int'(en_v), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {timeout_err, overrun_err}, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_last_latency", last_latency, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Adaptation frame
    mode = 1'b1;
    tick(1'b1, 1'b0);
    check("conv_first_enable", enable_conv, 1);
    wait_idle(200);

    // Cancellation frame; mid-frame mode flip must not matter
    mode = 1'b0;
    tick(1'b1, 1'b0);
    mode = 1'b1;
    wait_idle(200);
    check("errs_clean", {timeout_err, overrun_err}, 0);

    // Stale ready on conversion held through the arming window
    conv_stuck = 1'b1;
    tick(1'b1, 1'b1);
    wait_idle(200);
    check("conv_arm_exit", lag_rise_cyc - tick_cyc, 1 + PULSE + ARM + 1);
    conv_stuck = 1'b0;

    // Lag stage never ready
    lag_stuck = 1'b1;
    tick(1'b0, 1'b0);
    t = 0;
    while (!timeout_err && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_time", cyc - tick_cyc, 1 + (D + 1) + PULSE + TIMEOUT);
    wait_idle(50);
    check("timeout_frame_count", frame_count, fc_model);
    lag_stuck = 1'b0;
    tick(1'b1, 1'b0);
    wait_idle(200);
    check("timeout_sticky", timeout_err, 1);

    // Tick during PROC_WAIT
    tick(1'b1, 1'b0);
    repeat (24) @(negedge clk);
    scc = 13'd0;
    @(negedge clk);
    scc = 13'd1;
    check("overrun_err", overrun_err, 1);
    check("overrun_busy", busy, 1);
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("overrun_no_extra_frame", busy, 0);
    check("overrun_sb_empty", sb.size(), 0);
    check("overrun_frame_count", frame_count, fc_model);

    // Reset during LAG_EN
    tick(1'b1, 1'b0);
    repeat (11) @(negedge clk);
    check("pre_rst_enable_lag", enable_lag, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_enables", int'(en_v), 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {timeout_err, overrun_err}, 0);
    check("mid_rst_frame_count", frame_count, 0);
    sb.delete();
    fc_model = 0;
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    mode = 1'b0;
    tick(1'b1, 1'b0);
    wait_idle(200);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
